vga_param_controller: RTL

VGA_PARAM_CONTROLLER -- requirements
Module: vga_param_controller

---
 rtl/vga_param_controller_if.sv | 24 ++
 rtl/vga_param_controller.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_param_controller_if.sv
// Host pixel-fetch port of vga_param_controller: fetch request, coordinates and
// line/frame pulses out to the host, and the requested pixel colour back in.
interface vga_param_controller_if #(
   parameter int DATA_W = 10
);
   logic [DATA_W-1:0] iRed;
   logic [DATA_W-1:0] iGreen;
   logic [DATA_W-1:0] iBlue;
   logic              oRequest;
   logic [11:0]       oX;
   logic [11:0]       oY;
   logic              oFrameStart;
   logic              oLineStart;

   modport master (
      input  iRed, iGreen, iBlue,
      output oRequest, oX, oY, oFrameStart, oLineStart
   );

   modport slave (
      output iRed, iGreen, iBlue,
      input  oRequest, oX, oY, oFrameStart, oLineStart
   );
endinterface

// File: rtl/vga_param_controller.sv
// Parameterised VGA timing generator with a leading pixel-fetch request port.
// Optional colour-bar test pattern: define VGA_PARAM_CONTROLLER_PATTERN_EN.
module vga_param_controller #(
   parameter int DATA_W   = 10,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACT    = 640,
   parameter int H_FP     = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACT    = 480,
   parameter int V_FP     = 10,
   parameter int REQ_LEAD = 2,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iEN,
`ifdef VGA_PARAM_CONTROLLER_PATTERN_EN
   input  logic                  iPattern,
`endif
   vga_param_controller_if.master host,
   output logic [DATA_W-1:0]     oVGA_R,
   output logic [DATA_W-1:0]     oVGA_G,
   output logic [DATA_W-1:0]     oVGA_B,
   output logic                  oVGA_H_SYNC,
   output logic                  oVGA_V_SYNC,
   output logic                  oVGA_BLANK,
   output logic                  oVGA_SYNC,
   output logic                  oVGA_CLOCK
);

   localparam int H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
   localparam int V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
   localparam int H_ACT_START = H_SYNC + H_BP;
   localparam int V_ACT_START = V_SYNC + V_BP;

   localparam logic [11:0] C_H_LAST      = 12'(H_TOTAL - 1);
   localparam logic [11:0] C_V_LAST      = 12'(V_TOTAL - 1);
   localparam logic [11:0] C_H_SYNC      = 12'(H_SYNC);
   localparam logic [11:0] C_V_SYNC      = 12'(V_SYNC);
   localparam logic [11:0] C_H_ACT_START = 12'(H_ACT_START);
   localparam logic [11:0] C_H_ACT_END   = 12'(H_ACT_START + H_ACT);
   localparam logic [11:0] C_V_ACT_START = 12'(V_ACT_START);
   localparam logic [11:0] C_V_ACT_END   = 12'(V_ACT_START + V_ACT);
   // Request window is the active window shifted early; REQ_LEAD <= H_BP keeps it inside the line.
   localparam logic [11:0] C_H_REQ_START = 12'(H_ACT_START - REQ_LEAD);
   localparam logic [11:0] C_H_REQ_END   = 12'(H_ACT_START + H_ACT - REQ_LEAD);

   // Stage p0: raster counters
   logic [11:0] r_h_cnt_p0;
   logic [11:0] r_v_cnt_p0;
   logic        w_h_wrap;
   logic        w_v_wrap;

   assign w_h_wrap = (r_h_cnt_p0 == C_H_LAST);
   assign w_v_wrap = (r_v_cnt_p0 == C_V_LAST);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_h_cnt_p0 <= '0;
         r_v_cnt_p0 <= '0;
      end else if (!iEN) begin
         r_h_cnt_p0 <= '0;
         r_v_cnt_p0 <= '0;
      end else begin
         r_h_cnt_p0 <= w_h_wrap ? 12'd0 : r_h_cnt_p0 + 12'd1;
         if (w_h_wrap) begin
            r_v_cnt_p0 <= w_v_wrap ? 12'd0 : r_v_cnt_p0 + 12'd1;
         end
      end
   end

   logic              w_v_act;
   logic              w_act;
   logic              w_req;
   logic              w_req_en;
   logic [11:0]       w_x;
   logic [11:0]       w_y;
   logic [DATA_W-1:0] w_pix_r;
   logic [DATA_W-1:0] w_pix_g;
   logic [DATA_W-1:0] w_pix_b;

   assign w_v_act = (r_v_cnt_p0 >= C_V_ACT_START) && (r_v_cnt_p0 < C_V_ACT_END);
   assign w_act   = w_v_act && (r_h_cnt_p0 >= C_H_ACT_START) && (r_h_cnt_p0 < C_H_ACT_END);
   assign w_req   = w_req_en && w_v_act &&
                    (r_h_cnt_p0 >= C_H_REQ_START) && (r_h_cnt_p0 < C_H_REQ_END);
   assign w_x     = r_h_cnt_p0 - C_H_REQ_START;
   assign w_y     = r_v_cnt_p0 - C_V_ACT_START;

`ifdef VGA_PARAM_CONTROLLER_PATTERN_EN
   localparam int BAR_W = H_ACT / 8;

   logic [11:0] w_px;
   logic [2:0]  w_bar;

   always_comb begin
      w_px  = r_h_cnt_p0 - C_H_ACT_START;
      w_bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (w_px >= 12'(k * BAR_W)) begin
            w_bar = 3'(k);
         end
      end
   end

   // Bar order white..black maps to R = ~idx[1], G = ~idx[2], B = ~idx[0].
   assign w_req_en = ~iPattern;
   assign w_pix_r  = iPattern ? {DATA_W{~w_bar[1]}} : host.iRed;
   assign w_pix_g  = iPattern ? {DATA_W{~w_bar[2]}} : host.iGreen;
   assign w_pix_b  = iPattern ? {DATA_W{~w_bar[0]}} : host.iBlue;
`else
   assign w_req_en = 1'b1;
   assign w_pix_r  = host.iRed;
   assign w_pix_g  = host.iGreen;
   assign w_pix_b  = host.iBlue;
`endif

   // Stage p1: registered outputs, one cycle behind the counters
   logic              r_hs_p1;
   logic              r_vs_p1;
   logic              r_vld_p1;
   logic [DATA_W-1:0] r_red_p1;
   logic [DATA_W-1:0] r_grn_p1;
   logic [DATA_W-1:0] r_blu_p1;
   logic              r_req_p1;
   logic [11:0]       r_x_p1;
   logic [11:0]       r_y_p1;
   logic              r_fs_p1;
   logic              r_ls_p1;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_hs_p1  <= ~HS_POL;
         r_vs_p1  <= ~VS_POL;
         r_vld_p1 <= 1'b0;
         r_red_p1 <= '0;
         r_grn_p1 <= '0;
         r_blu_p1 <= '0;
         r_req_p1 <= 1'b0;
         r_x_p1   <= '0;
         r_y_p1   <= '0;
         r_fs_p1  <= 1'b0;
         r_ls_p1  <= 1'b0;
      end else if (!iEN) begin
         r_hs_p1  <= ~HS_POL;
         r_vs_p1  <= ~VS_POL;
         r_vld_p1 <= 1'b0;
         r_red_p1 <= '0;
         r_grn_p1 <= '0;
         r_blu_p1 <= '0;
         r_req_p1 <= 1'b0;
         r_x_p1   <= '0;
         r_y_p1   <= '0;
         r_fs_p1  <= 1'b0;
         r_ls_p1  <= 1'b0;
      end else begin
         r_hs_p1  <= (r_h_cnt_p0 < C_H_SYNC) ? HS_POL : ~HS_POL;
         r_vs_p1  <= (r_v_cnt_p0 < C_V_SYNC) ? VS_POL : ~VS_POL;
         r_vld_p1 <= w_act;
         r_red_p1 <= w_act ? w_pix_r : '0;
         r_grn_p1 <= w_act ? w_pix_g : '0;
         r_blu_p1 <= w_act ? w_pix_b : '0;
         r_req_p1 <= w_req;
         r_x_p1   <= w_req ? w_x : 12'd0;
         r_y_p1   <= w_req ? w_y : 12'd0;
         r_fs_p1  <= (r_h_cnt_p0 == 12'd0) && (r_v_cnt_p0 == 12'd0);
         r_ls_p1  <= (r_h_cnt_p0 == 12'd0);
      end
   end

   assign oVGA_H_SYNC      = r_hs_p1;
   assign oVGA_V_SYNC      = r_vs_p1;
   assign oVGA_BLANK       = r_vld_p1;
   assign oVGA_R           = r_red_p1;
   assign oVGA_G           = r_grn_p1;
   assign oVGA_B           = r_blu_p1;
   assign oVGA_SYNC        = 1'b0;
   assign oVGA_CLOCK       = iCLK;
   assign host.oRequest    = r_req_p1;
   assign host.oX          = r_x_p1;
   assign host.oY          = r_y_p1;
   assign host.oFrameStart = r_fs_p1;
   assign host.oLineStart  = r_ls_p1;

endmodule
